alu_muldiv: RTL

Parametrised, handshaked execution unit for the RV32 core. It combines the integer ALU operations with iterative multiply, divide and remainder. Single-cycle ops return one cycle after acceptance. MUL/DIV/REM run a WIDTH-step shift-add or restoring loop. The unit sits in the EX stage, and the pipeline stalls on `in_ready`/`out_valid`.

---
 rtl/alu_muldiv.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv.sv
// Handshaked RV32 execution unit: single-cycle ALU ops plus iterative
// shift-add multiply and restoring divide/remainder, one step per cycle.
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluctrl,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [1:0]       dbg_state
);
    // Handshake: an op is accepted on a rising edge where in_valid & in_ready;
    // a result is consumed on a rising edge where out_valid & out_ready, and
    // out_valid/result/zero stay stable until then (flush/rst excepted).
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] OP_AND = 4'd0, OP_OR = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4, OP_SLT = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8, OP_MUL = 4'd9, OP_MULH = 4'd10, OP_MULHU = 4'd11;
    localparam logic [3:0] OP_DIV = 4'd12, OP_DIVU = 4'd13, OP_REM = 4'd14;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                 state_q, state_d;
    logic [SHW-1:0]         cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic [3:0]             op_q, op_d;
    logic                   neg_q, neg_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic                   zero_q, zero_d;

    logic [SHW-1:0]         shamt;
    logic [WIDTH-1:0]       alu_res;
    logic                   op_signed, neg_in, div_zero, div_ovf, op_is_div;
    logic [WIDTH-1:0]       a_mag, b_mag;
    logic [WIDTH:0]         mul_sum, div_r;
    logic                   div_ge;
    logic [WIDTH-1:0]       div_rs;
    logic [2*WIDTH-1:0]     step_next;
    logic [WIDTH-1:0]       step_hi, step_lo, mulh_hi, fin_res;

    assign in_ready  = (state_q == IDLE) & ~flush & ~rst;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign dbg_state = state_q;

    assign shamt = src2[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (aluctrl)
            OP_AND: alu_res = src1 & src2;
            OP_OR:  alu_res = src1 | src2;
            OP_ADD: alu_res = src1 + src2;
            OP_SUB: alu_res = src1 - src2;
            OP_XOR: alu_res = src1 ^ src2;
            OP_SLT: alu_res = WIDTH'($signed(src1) < $signed(src2));
            OP_SLL: alu_res = src1 << shamt;
            OP_SRL: alu_res = src1 >> shamt;
            OP_SRA: alu_res = $signed(src1) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // Signed ops iterate on magnitudes; neg_in records the sign fix-up to apply at the end.
    assign op_signed = (aluctrl == OP_MULH) | (aluctrl == OP_DIV) | (aluctrl == OP_REM);
    assign op_is_div = aluctrl[3] & aluctrl[2];
    assign a_mag     = (op_signed & src1[WIDTH-1]) ? ('0 - src1) : src1;
    assign b_mag     = (op_signed & src2[WIDTH-1]) ? ('0 - src2) : src2;
    assign neg_in    = (aluctrl == OP_REM) ? src1[WIDTH-1]
                                           : (op_signed & (src1[WIDTH-1] ^ src2[WIDTH-1]));
    assign div_zero  = (src2 == '0);
    assign div_ovf   = (src1 == MIN_VAL) & (src2 == '1);

    // One shift-add (multiply) or one restoring subtract (divide) step on acc_q.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign div_r   = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ge  = (div_r >= {1'b0, b_q});
    assign div_rs  = div_ge ? (div_r[WIDTH-1:0] - b_q) : div_r[WIDTH-1:0];

    always_comb begin
        step_next = {div_rs, acc_q[WIDTH-2:0], div_ge};
        if ((op_q == OP_MUL) || (op_q == OP_MULH) || (op_q == OP_MULHU)) begin
            step_next = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    assign step_hi = step_next[2*WIDTH-1:WIDTH];
    assign step_lo = step_next[WIDTH-1:0];
    // High half of the negated double-width product, without forming the whole negation.
    assign mulh_hi = neg_q ? (~step_hi + WIDTH'(step_lo == '0)) : step_hi;

    always_comb begin
        fin_res = step_hi;
        case (op_q)
            OP_MUL:   fin_res = step_lo;
            OP_MULH:  fin_res = mulh_hi;
            OP_MULHU: fin_res = step_hi;
            OP_DIV:   fin_res = neg_q ? ('0 - step_lo) : step_lo;
            OP_DIVU:  fin_res = step_lo;
            OP_REM:   fin_res = neg_q ? ('0 - step_hi) : step_hi;
            default:  fin_res = step_hi;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        b_d      = b_q;
        op_d     = op_q;
        neg_d    = neg_q;
        result_d = result_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        op_d = aluctrl;
                        if (aluctrl < OP_MUL) begin
                            result_d = alu_res;
                            state_d  = DONE;
                        end else if (op_is_div && div_zero) begin
                            result_d = aluctrl[1] ? src1 : '1;
                            state_d  = DONE;
                        end else if (((aluctrl == OP_DIV) || (aluctrl == OP_REM)) && div_ovf) begin
                            result_d = aluctrl[1] ? '0 : MIN_VAL;
                            state_d  = DONE;
                        end else begin
                            acc_d   = {{WIDTH{1'b0}}, a_mag};
                            b_d     = b_mag;
                            neg_d   = neg_in;
                            cnt_d   = SHW'(WIDTH - 1);
                            state_d = BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc_d = step_next;
                    cnt_d = cnt_q - SHW'(1);
                    if (cnt_q == '0) begin
                        cnt_d    = '0;
                        result_d = fin_res;
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end
endmodule
